alu_issue_queue: RTL

Upstream feeder for the combinational ALU (inputs Rtype/Itype, output Y). It buffers incoming instructions in a small FIFO and issues them one at a time onto the ALU operand buses. It captures the ALU result one cycle after issue and presents it on a valid/ready result port. It also tracks occupancy, an issue counter and illegal-opcode errors.

---
 rtl/alu_issue_queue_if.sv | 35 +++
 rtl/alu_issue_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue_if.sv
// Bundles the instruction, ALU operand/result and status signals of alu_issue_queue.
// The slave modport is the queue's view, and the master modport is the feeder/consumer view.
`timescale 1ns/1ps
interface alu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DW-1:0]              in_instr;
  logic                       in_itype;
  logic [DW-1:0]              Rtype;
  logic [DW-1:0]              Itype;
  logic [DW-1:0]              alu_y;
  logic                       res_valid;
  logic                       res_ready;
  logic [DW-1:0]              res_data;
  logic [5:0]                 res_opcode;
  logic                       res_err;
  logic                       busy;
  logic [$clog2(DEPTH):0]     count;
  logic [7:0]                 issued_cnt;

  modport slave (
    input  in_valid, in_instr, in_itype, alu_y, res_ready,
    output in_ready, Rtype, Itype, res_valid, res_data, res_opcode, res_err,
           busy, count, issued_cnt
  );

  modport master (
    output in_valid, in_instr, in_itype, alu_y, res_ready,
    input  in_ready, Rtype, Itype, res_valid, res_data, res_opcode, res_err,
           busy, count, issued_cnt
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Buffers instructions in a DEPTH-entry FIFO and issues them one at a time onto the ALU operand buses.
// Latency: accept at edge N, operands are driven during cycle N+1, and res_valid is set from edge N+2; one result every 2 cycles.
// Backpressure: in_ready drops when the FIFO is full, and a held result (res_valid & !res_ready) stalls further issue.
`timescale 1ns/1ps
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;

  // Each entry holds {itype, instruction}
  logic [DW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  state_t         state_q;
  logic [DW-1:0]  instr_q;
  logic [DW-1:0]  rtype_q;
  logic [DW-1:0]  itype_q;
  logic [DW-1:0]  res_data_q;
  logic [5:0]     res_opcode_q;
  logic           res_err_q;
  logic           res_valid_q;
  logic [7:0]     issued_cnt_q;

  logic           in_ready;
  logic           push;
  logic           pop;
  logic [DW-1:0]  head_instr;
  logic           head_itype;
  logic [5:0]     issue_op;
  logic           issue_illegal;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd10, 6'd11: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

  // A full FIFO refuses pushes even if a pop happens in the same cycle (no bypass)
  assign in_ready      = (count_q < CW'(DEPTH));
  assign push          = bus.in_valid && in_ready;
  assign pop           = (count_q != '0) &&
                         ((state_q == IDLE) || ((state_q == RESULT) && bus.res_ready));
  assign head_instr    = mem_q[rd_ptr_q][DW-1:0];
  assign head_itype    = mem_q[rd_ptr_q][DW];
  assign issue_op      = instr_q[DW-1:DW-6];
  assign issue_illegal = !is_legal(issue_op);

  // FIFO pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset: entries are only read when count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_itype, bus.in_instr};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue FSM: the operand buses and result port are registered and loaded on the pop/exit edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      rtype_q      <= '0;
      itype_q      <= '0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            instr_q <= head_instr;
            rtype_q <= head_itype ? '0 : head_instr;
            itype_q <= head_itype ? head_instr : '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Illegal opcodes are still issued and counted; only the data is suppressed
          res_data_q   <= issue_illegal ? '0 : bus.alu_y;
          res_opcode_q <= issue_op;
          res_err_q    <= issue_illegal;
          res_valid_q  <= 1'b1;
          issued_cnt_q <= issued_cnt_q + 8'd1;
          rtype_q      <= '0;
          itype_q      <= '0;
          state_q      <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              instr_q <= head_instr;
              rtype_q <= head_itype ? '0 : head_instr;
              itype_q <= head_itype ? head_instr : '0;
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.Rtype      = rtype_q;
  assign bus.Itype      = itype_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_opcode = res_opcode_q;
  assign bus.res_err    = res_err_q;
  assign bus.busy       = (state_q != IDLE) || (count_q != '0);
  assign bus.count      = count_q;
  assign bus.issued_cnt = issued_cnt_q;
endmodule
